// File: rtl/pipelining_core_pkg.sv
// Shared constants for the three-stage arithmetic pipeline.
package pipelining_core_pkg;

  // Default datapath width used when the top is instantiated without overrides.
  localparam int DEFAULT_WIDTH = 10;

endpackage

// File: rtl/pipelining_core_pipe_reg.sv
// Generic pipeline register: clears to zero on async reset, loads d on clk rise.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the stage input each cycle; reset clears immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/pipelining_core.sv
// Three-stage pipeline computing f = ((a+b) + (c-d)) * d modulo 2^N.
// All arithmetic is unsigned and truncated to N bits at every stage.
// d is carried alongside the partial sums so that each stage works on one sample.
module pipelining_core
  import pipelining_core_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N-1:0] f
);

  logic [N-1:0] sum_ab;
  logic [N-1:0] diff_cd;
  logic [N-1:0] x1;
  logic [N-1:0] x2;
  logic [N-1:0] d1;
  logic [N-1:0] sum_x;
  logic [N-1:0] x3;
  logic [N-1:0] d2;
  logic [N-1:0] prod;

  // Stage 1 logic: carry dropped on the sum, difference wraps when c < d.
  always_comb begin
    sum_ab  = a + b;
    diff_cd = c - d;
  end

  pipe_reg #(.W(N)) u_x1 (.clk(clk), .rst(rst), .d(sum_ab),  .q(x1));
  pipe_reg #(.W(N)) u_x2 (.clk(clk), .rst(rst), .d(diff_cd), .q(x2));
  pipe_reg #(.W(N)) u_d1 (.clk(clk), .rst(rst), .d(d),       .q(d1));

  // Stage 2 logic: combine the two partial results of the same sample.
  always_comb begin
    sum_x = x1 + x2;
  end

  pipe_reg #(.W(N)) u_x3 (.clk(clk), .rst(rst), .d(sum_x), .q(x3));
  pipe_reg #(.W(N)) u_d2 (.clk(clk), .rst(rst), .d(d1),    .q(d2));

  // Stage 3 logic: only the low N bits of the product are kept.
  always_comb begin
    prod = x3 * d2;
  end

  pipe_reg #(.W(N)) u_f (.clk(clk), .rst(rst), .d(prod), .q(f));

endmodule

// File: tb/tb_pipelining_core.sv
// Bench for pipelining_core: directed table, random stream and reset corner cases.
module tb_pipelining_core;

  localparam int N = 10;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] f;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic [N-1:0] d;
  logic [N-1:0] f;

  int n_cmp;
  int n_err;

  logic [N-1:0] hist[$];
  vec_t         tbl[8];

  pipelining_core #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .f  (f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the whole formula evaluated with wide integers, then reduced mod 2^N.
  function automatic logic [N-1:0] ref_f(input logic [N-1:0] ia, ib, ic, id);
    longint unsigned m;
    longint unsigned s;
    m = longint'(1) << N;
    s = (longint'(ia) + longint'(ib) + longint'(ic) + m - longint'(id)) % m;
    return N'((s * longint'(id)) % m);
  endfunction

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Nothing in flight: the first two results after reset must read as zero.
  task automatic clear_model();
    hist = {};
    hist.push_back('0);
    hist.push_back('0);
  endtask

  // Drive one input set (called at a falling edge), clock it in, check f.
  task automatic step(input logic [N-1:0] ia, ib, ic, id, input string name);
    logic [N-1:0] exp;
    a = ia; b = ib; c = ic; d = id;
    @(posedge clk);
    if (rst) begin
      clear_model();
      exp = '0;
    end else begin
      hist.push_back(ref_f(ia, ib, ic, id));
      exp = hist.pop_front();
    end
    @(negedge clk);
    check(name, f, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    a = '0; b = '0; c = '0; d = '0;
    clear_model();

    tbl[0] = '{a:10,   b:5,  c:20, d:2,  f:66};
    tbl[1] = '{a:15,   b:25, c:12, d:4,  f:192};
    tbl[2] = '{a:30,   b:10, c:18, d:3,  f:165};
    tbl[3] = '{a:8,    b:7,  c:6,  d:5,  f:80};
    tbl[4] = '{a:50,   b:40, c:35, d:10, f:126};
    tbl[5] = '{a:0,    b:0,  c:0,  d:1,  f:1023};
    tbl[6] = '{a:1023, b:2,  c:7,  d:3,  f:15};
    tbl[7] = '{a:0,    b:0,  c:0,  d:0,  f:0};

    // Reset held with zero inputs, then released: f stays zero throughout.
    rst = 1'b1;
    #1;
    check("reset_async_initial", f, '0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, "reset_hold_zero");
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) step('0, '0, '0, '0, "post_reset_zero");

    // Single vector: result appears on the third rise, zeros before it.
    step(10, 5, 20, 2, "single_lat1");
    check("single_not_early1", f, '0);
    step('0, '0, '0, '0, "single_lat2");
    step('0, '0, '0, '0, "single_lat3");
    check("single_result", f, 10'd66);

    // Table applied back-to-back; entry i emerges after the rise of entry i+2.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, "table_model");
      if (i >= 2) check("table_expected", f, tbl[i-2].f);
    end
    step('0, '0, '0, '0, "table_flush1");
    check("table_expected", f, tbl[6].f);
    step('0, '0, '0, '0, "table_flush2");
    check("table_expected", f, tbl[7].f);

    // Random stream at full throughput.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] ra, rb, rc, rd;
      ra = N'($urandom); rb = N'($urandom); rc = N'($urandom); rd = N'($urandom);
      step(ra, rb, rc, rd, "random_stream");
    end

    // Mid-stream reset with a full pipeline: f clears without a clock edge.
    step(100, 200, 300, 7, "fill1");
    step(123, 45, 67, 9, "fill2");
    step(500, 20, 900, 11, "fill3");
    check("full_before_reset", f, ref_f(100, 200, 300, 7));
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", f, '0);
    @(posedge clk);
    #1;
    check("mid_reset_held", f, '0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    step(10, 5, 20, 2, "after_reset1");
    check("after_reset_discard1", f, '0);
    step(15, 25, 12, 4, "after_reset2");
    check("after_reset_discard2", f, '0);
    step(30, 10, 18, 3, "after_reset3");
    check("after_reset_result", f, 10'd66);
    step('0, '0, '0, '0, "after_reset4");
    check("after_reset_next", f, 10'd192);

    // More random traffic with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      logic [N-1:0] ra, rb, rc, rd;
      ra = N'($urandom); rb = N'($urandom); rc = N'($urandom); rd = N'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        #1;
        check("random_reset_async", f, '0);
        step(ra, rb, rc, rd, "random_reset_cycle");
        rst = 1'b0;
        clear_model();
      end else begin
        step(ra, rb, rc, rd, "random_stream2");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
